dm_responder: RTL and testbench

- Data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake, with a programmable wait-state latency.
- Performs little-endian byte/half/word stores and sign- or zero-extended loads.
- Returns a one-cycle response pulse; the MEM stage stalls on the request until `resp_valid`.

---
 rtl/dm_pkg.sv | 36 +++
 rtl/dm_lane_align.sv | 71 +++++++
 rtl/dm_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_dm_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
//   - dm_size_e   : request access-size encoding (byte/half/word/illegal)
//   - dm_state_e  : responder FSM state encoding
//   - CNT_W       : wait-state counter width (covers WAIT_CYCLES 0..15)
//   - dm_bad_shape: size/alignment legality helper
package dm_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } dm_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dm_state_e;

    localparam int CNT_W = 4;

    // True when the size code is illegal or the low address bits do not
    // match the natural alignment of the access.
    function automatic logic dm_bad_shape(input dm_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational little-endian lane steering.
// Ports:
//   addr_lo    in  2   byte offset within the word
//   size       in  2   access size (dm_size_e)
//   sign_ext   in  1   1 = sign-extend loads, 0 = zero-extend
//   wdata      in  32  right-aligned store data
//   rword      in  32  full word read from the array
//   be         out 4   byte-lane enables for a store
//   wdata_lane out 32  store data replicated into the addressed lanes
//   rdata_ext  out 32  extracted and extended load data
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  dm_size_e    size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection for the read side; shifting by the byte offset brings
    // the addressed lane down to bit 0.
    always_comb begin
        byte_s = 8'(rword >> {addr_lo, 3'b000});
        half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Byte enables, replicated write data and extended read data per size.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        case (size)
            SIZE_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                if (sign_ext) begin
                    rdata_ext = {{24{byte_s[7]}}, byte_s};
                end else begin
                    rdata_ext = {24'h00_0000, byte_s};
                end
            end
            SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                if (sign_ext) begin
                    rdata_ext = {{16{half_s[15]}}, half_s};
                end else begin
                    rdata_ext = {16'h0000, half_s};
                end
            end
            SIZE_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0000_0000;
                rdata_ext  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: target end of the MEM-stage load/store interface.
// One request at a time over valid/ready, WAIT_CYCLES wait states, then a
// one-cycle response pulse. Little-endian byte/half/word stores, sign- or
// zero-extended loads.
// Parameters: DEPTH_WORDS (array size in 32-bit words), WAIT_CYCLES (0..15).
// Ports:
//   clk, reset (synchronous, active-high)
//   req_valid/req_ready handshake; req_addr, req_write, req_size,
//   req_sign_ext, req_wdata request fields
//   resp_valid (pulse), resp_rdata (load data, 0 otherwise), resp_error
// Optional build macro: DM_WRITE_LOG_EN prints one line per store commit.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign_ext,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    dm_state_e        state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;

    logic [31:0] addr_r;
    logic        write_r;
    dm_size_e    size_r;
    logic        sign_r;
    logic [31:0] wdata_r;

    logic [31:0] eff_addr_s;
    logic        eff_write_s;
    dm_size_e    eff_size_s;
    logic        eff_sign_s;
    logic [31:0] eff_wdata_s;

    logic             accept_s;
    logic             commit_s;
    logic             err_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rword_s;
    logic [31:0]      merged_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_lane_s;
    logic [31:0]      rdata_ext_s;

    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_error_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    // RESP is only ever reached from IDLE or WAIT, so this marks the entry edge.
    assign commit_s   = (state_next_s == ST_RESP);
    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_error = resp_error_r;

    // Effective request: with no wait states RESP is entered on the accept
    // edge itself, before the latches hold the request, so use the live inputs.
    always_comb begin
        if (state_r == ST_IDLE) begin
            eff_addr_s  = req_addr;
            eff_write_s = req_write;
            eff_size_s  = dm_size_e'(req_size);
            eff_sign_s  = req_sign_ext;
            eff_wdata_s = req_wdata;
        end else begin
            eff_addr_s  = addr_r;
            eff_write_s = write_r;
            eff_size_s  = size_r;
            eff_sign_s  = sign_r;
            eff_wdata_s = wdata_r;
        end
    end

    // Error detection and array read for the effective request.
    always_comb begin
        err_s   = dm_bad_shape(eff_size_s, eff_addr_s[1:0]) ||
                  ({2'b00, eff_addr_s[31:2]} >= 32'(DEPTH_WORDS));
        idx_s   = eff_addr_s[IDX_W+1:2];
        rword_s = mem_r[idx_s];
    end

    dm_lane_align u_lane_align (
        .addr_lo    (eff_addr_s[1:0]),
        .size       (eff_size_s),
        .sign_ext   (eff_sign_s),
        .wdata      (eff_wdata_s),
        .rword      (rword_s),
        .be         (be_s),
        .wdata_lane (wdata_lane_s),
        .rdata_ext  (rdata_ext_s)
    );

    // Store merge: enabled lanes take new data, others keep the old word.
    always_comb begin
        merged_s = rword_s;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_s[8*i +: 8] = wdata_lane_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rword_s[8*i +: 8];
            end
        end
    end

    // FSM next-state and wait-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = CNT_LOAD;
                    end else begin
                        state_next_s = ST_RESP;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request latches, loaded on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= 32'h0000_0000;
            write_r <= 1'b0;
            size_r  <= SIZE_BYTE;
            sign_r  <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            write_r <= req_write;
            size_r  <= dm_size_e'(req_size);
            sign_r  <= req_sign_ext;
            wdata_r <= req_wdata;
        end
    end

    // Registered response, produced on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_error_r <= 1'b0;
        end else if (commit_s) begin
            resp_valid_r <= 1'b1;
            resp_error_r <= err_s;
            resp_rdata_r <= (err_s || eff_write_s) ? 32'h0000_0000 : rdata_ext_s;
        end else begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_error_r <= 1'b0;
        end
    end

    // Array write port; contents survive reset, but reset drops a pending store.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && eff_write_s && !err_s) begin
            mem_r[idx_s] <= merged_s;
        end
`ifdef DM_WRITE_LOG_EN
        if (!reset && commit_s && eff_write_s) begin
            if (err_s) begin
                $display("DM_ERR @%08h", eff_addr_s);
            end else begin
                $display("%0t @%08h: *%08h <= %08h", $time,
                         {eff_addr_s[31:2], 2'b00}, {eff_addr_s[31:2], 2'b00}, merged_s);
            end
        end
`endif
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
    localparam int PER   = WAITC + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign_ext;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_sign_ext (req_sign_ext),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
               (sz == 2'd2 && (a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Plain-arithmetic reference for the load result.
    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [31:0] w, v;
        w = model_mem[a / 4];
        v = w >> ((a % 4) * 8);
        if (sz == 2'd0) begin
            v = v % 256;
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, mask;
        int sh;
        sh = (a % 4) * 8;
        w  = model_mem[a / 4];
        if (sz == 2'd0) mask = 32'h0000_00FF;
        else if (sz == 2'd1) mask = 32'h0000_FFFF;
        else mask = 32'hFFFF_FFFF;
        w = (w & ~(mask << sh)) | ((wd & mask) << sh);
        model_mem[a / 4] = w;
    endtask

    // One full request/response transaction with handshake and timing checks.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int  lat;
        bit  seen;
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_sign_ext = sx; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
        req_size = 2'($urandom); req_sign_ext = 1'($urandom);
        seen = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i > 1) @(negedge clk);
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (resp_valid) begin
                seen = 1'b1; lat = i; rd = resp_rdata; er = resp_error;
            end
        end
        if (!seen) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(WAITC + 1));
            @(negedge clk);
            check("pulse_width", {31'd0, resp_valid}, 32'd0);
            check("ready_back", {31'd0, req_ready}, 32'd1);
        end
    endtask

    // Transaction checked against the reference model.
    task automatic run_op(input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        er, e_err;
        logic [31:0] e_rd;
        e_err = exp_err(sz, a);
        e_rd  = (e_err || wr) ? 32'd0 : exp_load(sz, sx, a);
        do_req(wr, sz, sx, a, wd, rd, er);
        check(wr ? "st_err" : "ld_err", {31'd0, er}, {31'd0, e_err});
        check(wr ? "st_rdata" : "ld_rdata", rd, e_rd);
        if (wr && !e_err) model_store(sz, a, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [31:0] a;
        logic        wr;
        int          pick;

        reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
        req_size = 2'd0; req_sign_ext = 1'b0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", {31'd0, resp_error}, 32'd0);
        reset = 1'b0;

        // Basic store/load and latency.
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
        check("lw_10", rd, 32'hDEAD_BEEF);

        // Byte/half stores and extended loads.
        run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, rd);
        run_op(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("sb_word", rd, 32'h1122_AA44);
        run_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_5566, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("sh_word", rd, 32'h5566_AA44);
        run_op(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, rd);
        check("lb_s", rd, 32'hFFFF_FFAA);
        run_op(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd);
        check("lbu", rd, 32'h0000_00AA);
        run_op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, rd);
        check("lh_s", rd, 32'h0000_5566);

        // Error cases.
        run_op(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, rd);
        run_op(1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_7777, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("sh_err_word", rd, 32'h5566_AA44);
        run_op(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, rd);
        run_op(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, rd);
        run_op(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h1234_5678, rd);
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("illegal_no_wr", rd, 32'h5566_AA44);

        // Continuous req_valid: accepts only in IDLE, one per PER cycles.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_sign_ext = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        for (int k = 0; k < 3 * PER; k++) begin
            if (k > 0) @(negedge clk);
            check("hs_ready", {31'd0, req_ready}, {31'd0, (k % PER) == 0});
            check("hs_valid", {31'd0, resp_valid}, {31'd0, (k % PER) == PER - 1});
            if (resp_valid) check("hs_rdata", resp_rdata, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        req_valid = 1'b0;

        // Reset during WAIT drops the store and the response.
        run_op(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, rd);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_sign_ext = 1'b0; req_addr = 32'h30; req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("abort_novalid", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        run_op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd);
        check("abort_word", rd, 32'hCAFE_F00D);

        // Randomized traffic over a small initialised window.
        for (int w = 0; w < 16; w++) begin
            run_op(1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, rd);
        end
        for (int n = 0; n < 200; n++) begin
            pick = int'($urandom_range(0, 19));
            wr   = 1'($urandom);
            sz   = 2'($urandom_range(0, 2));
            if (pick == 0) sz = 2'd3;
            if (pick == 1) a = 32'(4 * DEPTH) + $urandom_range(0, 63);
            else if (pick == 2) a = $urandom | 32'h8000_0000;
            else a = $urandom_range(0, 63);
            run_op(wr, sz, 1'($urandom), a, $urandom, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
